// File: rtl/cs3220_wb_pkg.sv
// ----------------------------------------------------------------------------
// cs3220_wb_pkg
// Shared Wishbone widths and the response record carried through the
// responder's latency pipeline.
//   WB_ADDR_W : word address width
//   WB_DATA_W : data bus width
//   WB_SEL_W  : byte-enable width (one bit per data byte)
//   wb_resp_t : {valid, err, is_read, data} as seen at the pipeline output
// ----------------------------------------------------------------------------
package cs3220_wb_pkg;

   localparam int WB_ADDR_W = 30;
   localparam int WB_DATA_W = 32;
   localparam int WB_SEL_W  = 4;

   typedef struct packed {
      logic                 valid;
      logic                 err;
      logic                 is_read;
      logic [WB_DATA_W-1:0] data;
   } wb_resp_t;

endpackage

// File: rtl/wb_byte_ram.sv
// ----------------------------------------------------------------------------
// wb_byte_ram
// Single-port word memory with per-byte write enables and a registered read.
// Contents are never cleared; there is deliberately no reset.
// Ports:
//   i_clk     : clock, rising edge
//   i_we      : write the bytes selected by i_sel at i_addr
//   i_re      : capture mem[i_addr] into o_rdata
//   i_addr    : word address
//   i_wdata   : write data
//   i_sel     : byte enables, bit n = byte n
//   o_rdata   : read data, valid the cycle after i_re
// ----------------------------------------------------------------------------
module wb_byte_ram
   import cs3220_wb_pkg::*;
#(
   parameter int DEPTH_WORDS = 1024,
   parameter int AW          = 10
) (
   input  logic                 i_clk,
   input  logic                 i_we,
   input  logic                 i_re,
   input  logic [AW-1:0]        i_addr,
   input  logic [WB_DATA_W-1:0] i_wdata,
   input  logic [WB_SEL_W-1:0]  i_sel,
   output logic [WB_DATA_W-1:0] o_rdata
);

   logic [WB_DATA_W-1:0] r_mem [DEPTH_WORDS];
   logic [WB_DATA_W-1:0] r_rdata;

   always_ff @(posedge i_clk) begin
      if (i_we) begin
         for (int b = 0; b < WB_SEL_W; b++) begin
            if (i_sel[b]) r_mem[i_addr][8*b +: 8] <= i_wdata[8*b +: 8];
         end
      end
      if (i_re) r_rdata <= r_mem[i_addr];
   end

   assign o_rdata = r_rdata;

endmodule

// File: rtl/wb_mem_responder.sv
// ----------------------------------------------------------------------------
// wb_mem_responder
// Pipelined Wishbone slave backed by a byte-enabled RAM. Every accepted
// request gets exactly one ack (in range) or err (out of range) LATENCY
// cycles later, in order. Dropping wb_cyc flushes pending responses.
// Optional periodic stall injection for exercising master flow control.
// Ports:
//   i_clk, i_reset_n         : clock / async active-low reset
//   wb_cyc, wb_stb, wb_we    : bus cycle, strobe, write enable
//   wb_addr                  : word address
//   wb_idata, wb_sel         : write data, byte enables
//   wb_ack, wb_err, wb_stall : response and flow control
//   wb_odata                 : read data (zero unless acking a read)
// ----------------------------------------------------------------------------
module wb_mem_responder
   import cs3220_wb_pkg::*;
#(
   parameter int DEPTH_WORDS  = 1024,
   parameter int LATENCY      = 2,
   parameter int STALL_PERIOD = 0
) (
   input  logic                 i_clk,
   input  logic                 i_reset_n,
   input  logic                 wb_cyc,
   input  logic                 wb_stb,
   input  logic                 wb_we,
   input  logic [WB_ADDR_W-1:0] wb_addr,
   input  logic [WB_DATA_W-1:0] wb_idata,
   input  logic [WB_SEL_W-1:0]  wb_sel,
   output logic                 wb_ack,
   output logic                 wb_err,
   output logic                 wb_stall,
   output logic [WB_DATA_W-1:0] wb_odata
);

   localparam int AW  = (DEPTH_WORDS > 1)  ? $clog2(DEPTH_WORDS)  : 1;
   localparam int SCW = (STALL_PERIOD > 1) ? $clog2(STALL_PERIOD) : 1;

   logic                 w_accept;
   logic                 w_in_range;
   logic [WB_DATA_W-1:0] w_ram_rdata;
   logic [WB_DATA_W-1:0] w_out_data;
   wb_resp_t             w_out;

   logic [LATENCY-1:0]   r_vld;
   logic [LATENCY-1:0]   r_err;
   logic [LATENCY-1:0]   r_rd;

   assign w_accept   = wb_cyc && wb_stb && !wb_stall;
   assign w_in_range = (wb_addr < WB_ADDR_W'(DEPTH_WORDS));

   generate
      if (STALL_PERIOD > 0) begin : g_stall
         logic [SCW-1:0] r_stall_cnt;

         always_ff @(posedge i_clk or negedge i_reset_n) begin
            if (!i_reset_n)                                   r_stall_cnt <= '0;
            else if (r_stall_cnt == SCW'(STALL_PERIOD - 1))   r_stall_cnt <= '0;
            else                                              r_stall_cnt <= r_stall_cnt + 1'b1;
         end

         assign wb_stall = wb_cyc && (r_stall_cnt == SCW'(STALL_PERIOD - 1));
      end else begin : g_no_stall
         assign wb_stall = 1'b0;
      end
   endgenerate

   // Out-of-range requests never reach the RAM, so they cannot alias onto
   // low addresses through the truncated index.
   wb_byte_ram #(
      .DEPTH_WORDS (DEPTH_WORDS),
      .AW          (AW)
   ) u_ram (
      .i_clk   (i_clk),
      .i_we    (w_accept && wb_we && w_in_range),
      .i_re    (w_accept && !wb_we && w_in_range),
      .i_addr  (wb_addr[AW-1:0]),
      .i_wdata (wb_idata),
      .i_sel   (wb_sel),
      .o_rdata (w_ram_rdata)
   );

   // Control pipeline: stage 0 is loaded at the acceptance edge, the last
   // stage drives the bus. Losing wb_cyc empties it on the next edge, and
   // the outputs are gated by wb_cyc so the flush is visible at once.
   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         r_vld <= '0;
         r_err <= '0;
         r_rd  <= '0;
      end else if (!wb_cyc) begin
         r_vld <= '0;
      end else begin
         r_vld[0] <= w_accept;
         r_err[0] <= !w_in_range;
         r_rd[0]  <= !wb_we;
         for (int i = 1; i < LATENCY; i++) begin
            r_vld[i] <= r_vld[i-1];
            r_err[i] <= r_err[i-1];
            r_rd[i]  <= r_rd[i-1];
         end
      end
   end

   // RAM output already lines up with stage 0; extra stages only delay data.
   generate
      if (LATENCY > 1) begin : g_data_pipe
         logic [WB_DATA_W-1:0] r_data [1:LATENCY-1];

         always_ff @(posedge i_clk) begin
            r_data[1] <= w_ram_rdata;
            for (int i = 2; i < LATENCY; i++) r_data[i] <= r_data[i-1];
         end

         assign w_out_data = r_data[LATENCY-1];
      end else begin : g_data_direct
         assign w_out_data = w_ram_rdata;
      end
   endgenerate

   assign w_out = '{valid:   r_vld[LATENCY-1],
                    err:     r_err[LATENCY-1],
                    is_read: r_rd[LATENCY-1],
                    data:    w_out_data};

   assign wb_ack   = wb_cyc && w_out.valid && !w_out.err;
   assign wb_err   = wb_cyc && w_out.valid &&  w_out.err;
   assign wb_odata = (wb_ack && w_out.is_read) ? w_out.data : '0;

endmodule

// File: tb/tb_wb_mem_responder.sv
// ----------------------------------------------------------------------------
// tb_wb_mem_responder
// Directed stimulus with hand-computed expectations pushed into a queue at
// acceptance; a negedge monitor pops and checks every ack/err for kind,
// timing and data, and checks stall/idle behaviour each cycle.
// ----------------------------------------------------------------------------
module tb_wb_mem_responder;

   localparam int DEPTH = 1024;
   localparam int LAT   = 2;
   localparam int SP    = 3;

   logic        clk   = 1'b0;
   logic        rst_n = 1'b0;
   logic        cyc, stb, we;
   logic [29:0] addr;
   logic [31:0] idata;
   logic [3:0]  sel;
   logic        ack, err, stall;
   logic [31:0] odata;

   always #5 clk = ~clk;

   wb_mem_responder #(
      .DEPTH_WORDS  (DEPTH),
      .LATENCY      (LAT),
      .STALL_PERIOD (SP)
   ) dut (
      .i_clk     (clk),
      .i_reset_n (rst_n),
      .wb_cyc    (cyc),
      .wb_stb    (stb),
      .wb_we     (we),
      .wb_addr   (addr),
      .wb_idata  (idata),
      .wb_sel    (sel),
      .wb_ack    (ack),
      .wb_err    (err),
      .wb_stall  (stall),
      .wb_odata  (odata)
   );

   typedef struct {
      int          due;
      logic        err;
      logic [31:0] data;
   } exp_t;

   exp_t q[$];
   int   n_vec = 0;
   int   n_miss = 0;
   int   edge_cnt = 0;
   int   sc;
   int   last_tries;

   always @(posedge clk) edge_cnt <= edge_cnt + 1;

   // Expected stall phase: free-running 0..SP-1, cleared by reset.
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) sc <= 0;
      else        sc <= (sc == SP - 1) ? 0 : sc + 1;
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
      n_vec++;
      if (act !== exp_v) begin
         n_miss++;
         $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp_v, $time);
      end
   endtask

   always @(negedge clk) begin
      exp_t e;
      if (rst_n) begin
         chk("stall", {31'b0, stall}, {31'b0, cyc && (sc == SP - 1)});
         chk("ack_err_excl", {31'b0, ack && err}, 32'h0);
         if (ack || err) begin
            if (q.size() == 0) begin
               chk("unexpected_resp", {30'b0, ack, err}, 32'h0);
            end else begin
               e = q.pop_front();
               chk("resp_cycle", edge_cnt, e.due);
               chk("resp_kind", {30'b0, ack, err}, e.err ? 32'd1 : 32'd2);
               chk("resp_odata", odata, e.data);
            end
         end else begin
            chk("odata_idle", odata, 32'h0);
            if (q.size() != 0 && q[0].due < edge_cnt) begin
               e = q.pop_front();
               chk("missing_resp_due", edge_cnt, e.due);
            end
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input int n);
      repeat (n) tick();
   endtask

   // Present a request and hold it until an edge with stall low takes it.
   task automatic req(input logic w, input logic [29:0] a, input logic [31:0] d,
                      input logic [3:0] s, input logic exp_err, input logic [31:0] exp_d);
      logic st;
      exp_t e;
      cyc = 1'b1; stb = 1'b1; we = w; addr = a; idata = d; sel = s;
      last_tries = 0;
      do begin
         @(negedge clk);
         st = stall;
         @(posedge clk);
         #1;
         last_tries++;
      end while (st && last_tries < 10);
      chk("accept", {31'b0, st}, 32'h0);
      e.due  = edge_cnt + LAT - 1;
      e.err  = exp_err;
      e.data = exp_d;
      if (!st) q.push_back(e);
      stb = 1'b0; we = 1'b0;
   endtask

   task automatic wr(input logic [29:0] a, input logic [31:0] d, input logic [3:0] s);
      req(1'b1, a, d, s, a >= DEPTH, 32'h0);
   endtask

   task automatic rd(input logic [29:0] a, input logic [31:0] exp_d);
      req(1'b0, a, 32'h0, 4'hF, a >= DEPTH, (a >= DEPTH) ? 32'h0 : exp_d);
   endtask

   initial begin
      cyc = 1'b0; stb = 1'b0; we = 1'b0; addr = '0; idata = '0; sel = '0;
      #12;
      chk("reset_ack_err_stall", {29'b0, ack, err, stall}, 32'h0);
      chk("reset_odata", odata, 32'h0);
      tick();
      rst_n = 1'b1;

      // first request taken on the first edge after reset release
      wr(30'd5, 32'hDEADBEEF, 4'hF);
      chk("first_accept_tries", last_tries, 32'd1);
      rd(30'd5, 32'hDEADBEEF);

      wr(30'd5, 32'h000000AA, 4'h1);
      rd(30'd5, 32'hDEADBEAA);
      wr(30'd5, 32'h11223344, 4'h0);
      rd(30'd5, 32'hDEADBEAA);
      wr(30'd5, 32'h55667788, 4'hA);
      rd(30'd5, 32'h55AD77AA);

      for (int i = 0; i < 8; i++) wr(30'(i), 32'hA5000000 | i, 4'hF);

      // out of range: err, no data, no aliasing onto word 0
      rd(30'd1024, 32'h0);
      wr(30'd1024, 32'hFFFFFFFF, 4'hF);
      rd(30'd0, 32'hA5000000);
      rd(30'h3FFFFFFF, 32'h0);

      for (int i = 0; i < 8; i++) rd(30'(i), 32'hA5000000 | i);
      idle(4);
      chk("queue_drained", q.size(), 32'd0);

      // drop wb_cyc for one cycle right after acceptance: response discarded
      rd(30'd3, 32'hA5000003);
      q.delete();
      cyc = 1'b0;
      tick();
      cyc = 1'b1;
      idle(4);
      rd(30'd4, 32'hA5000004);
      idle(4);

      // reset with two reads in flight
      rd(30'd6, 32'hA5000006);
      rd(30'd7, 32'hA5000007);
      rst_n = 1'b0;
      #1;
      chk("rst_inflight_ack_err_stall", {29'b0, ack, err, stall}, 32'h0);
      chk("rst_inflight_odata", odata, 32'h0);
      q.delete();
      idle(2);
      rst_n = 1'b1;
      idle(4);
      rd(30'd2, 32'hA5000002);
      idle(4);
      chk("final_queue_empty", q.size(), 32'd0);

      cyc = 1'b0;
      idle(2);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule
